// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: sequential instruction prefetcher feeding a single-cycle core.
// Fetches words over a req/ack memory port into a DEPTH-entry FIFO and presents
// {inst, inst_pc} to the core over valid/ready. A redirect flushes and restarts fetch.
// Optional statistics counters are enabled by defining PREFETCH_STATS_EN.
`timescale 1ns/1ps

module fetch_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic                   CLK,
  input  logic                   resetl,
  input  logic [PC_W-1:0]        startpc,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   mem_req,
  output logic [PC_W-1:0]        mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst,
  output logic [PC_W-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0] count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [15:0]            flush_count,
  output logic [15:0]            discard_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {LOAD, FETCH, FULL} state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic            r_drop;
  logic            r_mem_req;
  logic [PC_W-1:0] r_mem_addr;
  logic [CW-1:0]   r_count;
  logic            r_inst_valid;
  logic [31:0]     r_inst_q [DEPTH];
  logic [PC_W-1:0] r_pc_q   [DEPTH];

  logic            w_ack;
  logic            w_pop;
  logic            w_flush;
  logic            w_room;
  logic            w_push;
  logic [CW-1:0]   w_wr_idx;
  logic [CW-1:0]   w_count_next;
  logic [PC_W-1:0] w_fetch_pc_inc;

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst_q[0];
  assign inst_pc    = r_pc_q[0];
  assign count      = r_count;

  // Per-cycle handshake decode: acks only count against an outstanding request,
  // and a redirect (outside LOAD) overrides any push in the same cycle.
  always_comb begin
    w_ack          = r_mem_req & mem_ack;
    w_pop          = r_inst_valid & inst_ready;
    w_flush        = redirect & (r_state != LOAD);
    w_room         = (r_count != FULL_CNT) | w_pop;
    w_push         = w_ack & ~r_drop & ~w_flush & w_room & (r_state == FETCH);
    w_wr_idx       = r_count - CW'(w_pop);
    w_fetch_pc_inc = r_fetch_pc + PC_W'(4);
    w_count_next   = r_count;
    if (w_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Fetch FSM with registered memory request, occupancy and valid flag.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state      <= LOAD;
      r_fetch_pc   <= '0;
      r_drop       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_count      <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_count      <= w_count_next;
      r_inst_valid <= (w_count_next != '0);
      if (r_state == LOAD) begin
        r_fetch_pc <= startpc;
        r_state    <= FETCH;
        r_mem_req  <= 1'b1;
        r_mem_addr <= startpc;
        r_drop     <= 1'b0;
      end else if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_state    <= FETCH;
        r_mem_req  <= 1'b1;
        if (r_mem_req && !mem_ack) begin
          r_drop <= 1'b1;
        end else begin
          r_drop     <= 1'b0;
          r_mem_addr <= redirect_pc;
        end
      end else if (r_state == FETCH) begin
        if (w_ack) begin
          r_drop <= 1'b0;
          if (w_push) begin
            r_fetch_pc <= w_fetch_pc_inc;
          end
          if (w_count_next == FULL_CNT) begin
            r_state   <= FULL;
            r_mem_req <= 1'b0;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_push ? w_fetch_pc_inc : r_fetch_pc;
          end
        end
      end else begin
        if (w_pop) begin
          r_state    <= FETCH;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_fetch_pc;
        end
      end
    end
  end

  // Shift-register FIFO: entry 0 is the registered head; pushes land just past the survivors.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_q[i] <= '0;
        r_pc_q[i]   <= '0;
      end
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r_inst_q[i] <= r_inst_q[i+1];
          r_pc_q[i]   <= r_pc_q[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_wr_idx == CW'(i))) begin
          r_inst_q[i] <= mem_rdata;
          r_pc_q[i]   <= r_fetch_pc;
        end
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  logic [15:0] r_discard_count;
  logic        w_discard;

  assign w_discard     = w_ack & (r_drop | w_flush);
  assign stall_cycles  = r_stall_cycles;
  assign flush_count   = r_flush_count;
  assign discard_count = r_discard_count;

  // Saturating event counters for starvation, accepted redirects and dropped words.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_discard_count <= '0;
    end else begin
      if (inst_ready && !r_inst_valid && (r_state != LOAD) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
      if (w_discard && (r_discard_count != '1)) begin
        r_discard_count <= r_discard_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: directed self-checking bench for fetch_prefetch_buffer.
// A behavioural memory returns wordAt(addr) after a programmable latency, or the
// bench drives the ack by hand for cycle-exact redirect scenarios.
// Counter ports are exercised when PREFETCH_STATS_EN is defined.
`timescale 1ns/1ps

module tb_fetch_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;

  logic              CLK = 1'b0;
  logic              resetl = 1'b0;
  logic [PC_W-1:0]   startpc = '0;
  logic              redirect = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [31:0]       inst;
  logic [PC_W-1:0]   inst_pc;
  logic [$clog2(DEPTH):0] count;
`ifdef PREFETCH_STATS_EN
  logic [31:0]       stall_cycles;
  logic [15:0]       flush_count;
  logic [15:0]       discard_count;
`endif

  int                testsRun = 0;
  int                testsFailed = 0;

  logic              memAuto = 1'b1;
  int                memLatency = 1;
  logic              autoAck;
  logic [31:0]       autoData;
  logic              manualAck = 1'b0;
  logic [31:0]       manualData = '0;
  int                ackCount;
  int                memWait;

  assign mem_ack   = memAuto ? autoAck  : manualAck;
  assign mem_rdata = memAuto ? autoData : manualData;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK         (CLK),
    .resetl      (resetl),
    .startpc     (startpc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .count       (count)
`ifdef PREFETCH_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .discard_count (discard_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Instruction image: every word is its own address tagged with a fixed pattern.
  function automatic logic [31:0] wordAt(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Hold reset, configure memory and ready, optionally check reset values, then release.
  task automatic applyStimulus(input logic [63:0] start, input int lat, input logic useAuto,
                               input logic ready, input logic checkReset);
    resetl      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    manualAck   = 1'b0;
    manualData  = '0;
    memAuto     = useAuto;
    memLatency  = lat;
    startpc     = start;
    tick();
    tick();
    if (checkReset) begin
      checkOutput("rst_mem_req",    64'(mem_req),    64'd0);
      checkOutput("rst_mem_addr",   mem_addr,        64'd0);
      checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
      checkOutput("rst_inst",       64'(inst),       64'd0);
      checkOutput("rst_inst_pc",    inst_pc,         64'd0);
      checkOutput("rst_count",      64'(count),      64'd0);
    end
    inst_ready = ready;
    resetl     = 1'b1;
  endtask

  // Behavioural memory: acks mem_req after memLatency cycles with a one-cycle pulse.
  initial begin
    autoAck  = 1'b0;
    autoData = '0;
    ackCount = 0;
    memWait  = 0;
    forever begin
      @(posedge CLK);
      #1;
      autoAck = 1'b0;
      if (!resetl || !memAuto) begin
        memWait = 0;
      end else if (mem_req) begin
        memWait++;
        if (memWait >= memLatency) begin
          autoAck  = 1'b1;
          autoData = wordAt(mem_addr);
          ackCount++;
          memWait  = 0;
        end
      end
    end
  end

  initial begin
    logic [63:0] expPc;
    logic [63:0] wrapPcs [3];
    int          ackBase;
    logic        sawBad;
    int          n;

    // Reset, LOAD and sequential delivery from 0x400
    applyStimulus(64'h400, 1, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (n < 3 && !inst_valid) begin tick(); n++; end
    checkOutput("first_valid_within_3", 64'(inst_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      expPc = 64'h400 + 64'(4 * k);
      n = 0;
      while (n < 5 && !inst_valid) begin tick(); n++; end
      checkOutput("seq_inst_pc", inst_pc, expPc);
      checkOutput("seq_inst",    64'(inst), 64'(wordAt(expPc)));
      tick();
    end

    // Fill with backpressure, then free one slot
    applyStimulus(64'h400, 1, 1'b1, 1'b0, 1'b0);
    ackBase = ackCount;
    for (int k = 0; k < 8; k++) tick();
    checkOutput("fill_ack_count", 64'(ackCount - ackBase), 64'd4);
    checkOutput("fill_mem_req",   64'(mem_req),            64'd0);
    checkOutput("fill_count",     64'(count),              64'd4);
    checkOutput("fill_head_pc",   inst_pc,                 64'h400);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checkOutput("pop_count",   64'(count), 64'd3);
    checkOutput("pop_head_pc", inst_pc,    64'h404);
    n = 0;
    while (n < 3 && !mem_req) begin tick(); n++; end
    checkOutput("refill_req",  64'(mem_req), 64'd1);
    checkOutput("refill_addr", mem_addr,     64'h410);

    // Redirect while a 3-cycle request to 0x40C is outstanding
    applyStimulus(64'h400, 3, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (n < 40 && !(mem_req && mem_addr == 64'h40C)) begin tick(); n++; end
    checkOutput("req_40C_seen", 64'(mem_req && mem_addr == 64'h40C), 64'd1);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h800;
    tick();
    redirect = 1'b0;
    checkOutput("rd_flush_count", 64'(count),      64'd0);
    checkOutput("rd_flush_valid", 64'(inst_valid), 64'd0);
    checkOutput("rd_hold_addr",   mem_addr,        64'h40C);
    sawBad = 1'b0;
    n = 0;
    while (n < 10 && mem_addr != 64'h800) begin
      if (inst_valid && inst_pc == 64'h40C) sawBad = 1'b1;
      tick();
      n++;
    end
    checkOutput("rd_new_addr", mem_addr, 64'h800);
    n = 0;
    while (n < 10 && !inst_valid) begin
      if (inst_valid && inst_pc == 64'h40C) sawBad = 1'b1;
      tick();
      n++;
    end
    checkOutput("rd_first_pc",   inst_pc,     64'h800);
    checkOutput("rd_first_inst", 64'(inst),   64'(wordAt(64'h800)));
    checkOutput("rd_no_40C",     64'(sawBad), 64'd0);

    // Redirect coinciding with ack and pop while holding two entries
    applyStimulus(64'h400, 1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("man_addr0", mem_addr, 64'h400);
    manualAck = 1'b1; manualData = wordAt(64'h400);
    tick();
    manualAck = 1'b1; manualData = wordAt(64'h404);
    tick();
    manualAck = 1'b0;
    checkOutput("man_count2", 64'(count), 64'd2);
    checkOutput("man_addr2",  mem_addr,   64'h408);
    manualAck   = 1'b1;
    manualData  = wordAt(64'h408);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'hA00;
    tick();
    manualAck  = 1'b0;
    inst_ready = 1'b0;
    redirect   = 1'b0;
    checkOutput("co_count",   64'(count),      64'd0);
    checkOutput("co_valid",   64'(inst_valid), 64'd0);
    checkOutput("co_req",     64'(mem_req),    64'd1);
    checkOutput("co_addr",    mem_addr,        64'hA00);
    manualAck = 1'b1; manualData = wordAt(64'hA00);
    tick();
    manualAck = 1'b0;
    checkOutput("co_new_pc",    inst_pc,   64'hA00);
    checkOutput("co_new_inst",  64'(inst), 64'(wordAt(64'hA00)));
    checkOutput("co_new_count", 64'(count), 64'd1);
`ifdef PREFETCH_STATS_EN
    checkOutput("stat_flush",   64'(flush_count),   64'd1);
    checkOutput("stat_discard", 64'(discard_count), 64'd1);
`endif

    // PC wrap across the top of the address space
    wrapPcs[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    wrapPcs[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    wrapPcs[2] = 64'h0;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF8, 1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (n < 5 && !inst_valid) begin tick(); n++; end
      checkOutput("wrap_pc",   inst_pc,   wrapPcs[k]);
      checkOutput("wrap_inst", 64'(inst), 64'(wordAt(wrapPcs[k])));
      tick();
    end

    // Asynchronous reset between edges while a request is pending
    applyStimulus(64'h400, 3, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (n < 20 && !(mem_req && count != 0)) begin tick(); n++; end
    checkOutput("async_pre_busy", 64'(mem_req && count != 0), 64'd1);
    #2;
    resetl = 1'b0;
    #1;
    checkOutput("async_mem_req", 64'(mem_req),    64'd0);
    checkOutput("async_valid",   64'(inst_valid), 64'd0);
    checkOutput("async_count",   64'(count),      64'd0);
`ifdef PREFETCH_STATS_EN
    checkOutput("async_stall",   64'(stall_cycles),  64'd0);
    checkOutput("async_flush",   64'(flush_count),   64'd0);
    checkOutput("async_discard", 64'(discard_count), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
